// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-requester register-file write arbiter, round-robin (fixed priority when RF_ARB_FIXED_PRIO_EN is defined)
module rf_write_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [2:0]        addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [2:0]        addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic [7:0]        we,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_gnt
);

  logic              r_gnt0;
  logic              r_gnt1;
  logic [7:0]        r_we;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_last_gnt;
  // Low through the first edge after reset release, so that edge never grants.
  logic              r_armed;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_pick1;
  logic              w_grant;
  logic [2:0]        w_addr;
  logic [7:0]        w_we;

  // Pick a winner among eligible requesters; a requester granted this cycle
  // sits out the next edge so a held req alternates with the other side.
  always_comb begin
    w_elig0 = req0 & ~r_gnt0;
    w_elig1 = req1 & ~r_gnt1;
    w_pick1 = 1'b0;
    if (w_elig0 && w_elig1) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      w_pick1 = 1'b0;
`else
      w_pick1 = ~r_last_gnt;
`endif
    end else begin
      w_pick1 = w_elig1;
    end
    w_grant = r_armed & (w_elig0 | w_elig1);
    w_addr  = w_pick1 ? addr1 : addr0;
    w_we    = 8'b0000_0001 << w_addr;
  end

  // Register the grant, one-hot write enable, datum and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_we       <= 8'h00;
      r_wr_data  <= '0;
      r_last_gnt <= 1'b1;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_grant) begin
        r_gnt0     <= ~w_pick1;
        r_gnt1     <= w_pick1;
        r_we       <= w_we;
        r_wr_data  <= w_pick1 ? data1 : data0;
        r_last_gnt <= w_pick1;
      end else begin
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
        r_we   <= 8'h00;
      end
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign we       = r_we;
  assign wr_data  = r_wr_data;
  assign last_gnt = r_last_gnt;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic              req0;
  logic [2:0]        addr0;
  logic [DATA_W-1:0] data0;
  logic              gnt0;
  logic              req1;
  logic [2:0]        addr1;
  logic [DATA_W-1:0] data1;
  logic              gnt1;
  logic [7:0]        we;
  logic [DATA_W-1:0] wr_data;
  logic              last_gnt;

  int n_checks;
  int n_pass;

  rf_write_arbiter #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .addr0    (addr0),
    .data0    (data0),
    .gnt0     (gnt0),
    .req1     (req1),
    .addr1    (addr1),
    .data1    (data1),
    .gnt1     (gnt1),
    .we       (we),
    .wr_data  (wr_data),
    .last_gnt (last_gnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic g0, input logic g1, input logic [7:0] w,
                           input logic [DATA_W-1:0] d, input logic lg);
    check({tag, ".gnt0"}, {63'd0, gnt0}, {63'd0, g0});
    check({tag, ".gnt1"}, {63'd0, gnt1}, {63'd0, g1});
    check({tag, ".we"}, {56'd0, we}, {56'd0, w});
    check({tag, ".wr_data"}, {32'd0, wr_data}, {32'd0, d});
    check({tag, ".last_gnt"}, {63'd0, last_gnt}, {63'd0, lg});
  endtask

  logic [7:0]        exp_we [4];
  logic              exp_g1 [4];
  logic [DATA_W-1:0] exp_d  [4];
  bit                seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b1;
    req0 = 1'b0; addr0 = 3'd0; data0 = '0;
    req1 = 1'b0; addr1 = 3'd0; data1 = '0;
    #1 reset_n = 1'b0;
    #2;
    check_out("reset", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);

    // Single request, released less than a cycle before the next edge.
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 3'b101; data0 = 32'hA5A5_A5A5;
    reset_n = 1'b1;
    tick();
    check_out("first_edge", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    tick();
    check_out("single_c1", 1'b1, 1'b0, 8'b0010_0000, 32'hA5A5_A5A5, 1'b0);
    tick();
    check_out("single_c2", 1'b0, 1'b0, 8'h00, 32'hA5A5_A5A5, 1'b0);
    req0 = 1'b0;
    tick();

    // Tie after a fresh reset: alternates 0,1,0,1 starting with requester 0.
    reset_n = 1'b0;
    #1;
    check_out("reset2", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 3'd0; data0 = 32'h0000_0010;
    req1 = 1'b1; addr1 = 3'd7; data1 = 32'h0000_0011;
    reset_n = 1'b1;
    tick();
    check_out("tie_arm", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    exp_we[0] = 8'h01; exp_g1[0] = 1'b0; exp_d[0] = 32'h10;
    exp_we[1] = 8'h80; exp_g1[1] = 1'b1; exp_d[1] = 32'h11;
    exp_we[2] = 8'h01; exp_g1[2] = 1'b0; exp_d[2] = 32'h10;
    exp_we[3] = 8'h80; exp_g1[3] = 1'b1; exp_d[3] = 32'h11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("tie_c%0d", i), ~exp_g1[i], exp_g1[i], exp_we[i], exp_d[i], exp_g1[i]);
    end

    // Reset during the gnt1 pulse clears everything at once.
    req0 = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_out("midreset", 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!seen) begin
        tick();
        if (gnt1) begin
          seen = 1'b1;
          check("rearb.we", {56'd0, we}, 64'h80);
          check("rearb.wr_data", {32'd0, wr_data}, 64'h11);
        end
      end
    end
    check("rearb.gnt1_within_2", {63'd0, seen}, 64'd1);
    req1 = 1'b0;
    tick();
    check_out("rearb_idle", 1'b0, 1'b0, 8'h00, 32'h11, 1'b1);

    // Same address from both sides: two separate writes, requester 0 first.
    req0 = 1'b1; addr0 = 3'd3; data0 = 32'h1;
    req1 = 1'b1; addr1 = 3'd3; data1 = 32'h2;
    tick();
    check_out("same_c1", 1'b1, 1'b0, 8'h08, 32'h1, 1'b0);
    tick();
    check_out("same_c2", 1'b0, 1'b1, 8'h08, 32'h2, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Idle: nothing moves for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("idle_c%0d", i), 1'b0, 1'b0, 8'h00, 32'h2, 1'b1);
    end

    // Tie with last_gnt=0: round-robin gives requester 1, fixed priority gives 0.
    req0 = 1'b1; addr0 = 3'd2; data0 = 32'h20;
    tick();
    check_out("solo0", 1'b1, 1'b0, 8'h04, 32'h20, 1'b0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1; addr1 = 3'd6; data1 = 32'h60;
    tick();
`ifdef RF_ARB_FIXED_PRIO_EN
    check_out("tie_lg0", 1'b1, 1'b0, 8'h04, 32'h20, 1'b0);
`else
    check_out("tie_lg0", 1'b0, 1'b1, 8'h40, 32'h60, 1'b1);
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check_out("end_idle", 1'b0, 1'b0, 8'h00,
`ifdef RF_ARB_FIXED_PRIO_EN
              32'h20, 1'b0);
`else
              32'h60, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL take parameter DATA_W, default 32, the width in bits of each register-file write datum.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1 bit: requester 0 write request, held high until granted.
REQ-005 SHALL have port addr0, input, 3 bits: requester 0 destination register index.
REQ-006 SHALL have port data0, input, DATA_W bits: requester 0 write data.
REQ-007 SHALL have port gnt0, output, 1 bit: requester 0 grant, a one-cycle pulse.
REQ-008 SHALL have ports req1, addr1, data1 and gnt1, identical in direction, width and meaning to REQ-004..007, for requester 1.
REQ-009 SHALL have port we, output, 8 bits: one-hot register write enable, all zero when idle.
REQ-010 SHALL have port wr_data, output, DATA_W bits: the write datum for the enabled register.
REQ-011 SHALL have port last_gnt, output, 1 bit: index of the most recent winner; this is the round-robin pointer.

Function
REQ-012 SHALL register all outputs, so a request sampled at edge N produces gnt, we and wr_data during cycle N+1, a latency of 1 cycle.
REQ-013 SHALL treat a requester as eligible at an edge only if its req is 1 and its gnt is currently 0, so a held req is never granted on two consecutive cycles.
REQ-014 SHALL, with exactly one requester eligible, grant that requester.
REQ-015 SHALL, with both eligible, grant the requester that is not last_gnt (round-robin).
REQ-016 SHALL, on a grant to requester k, set gnt_k=1, we=(1<<addr_k), wr_data=data_k and last_gnt=k for exactly one cycle.
REQ-017 SHALL, with no eligible requester, drive gnt0=gnt1=0 and we=8'h00, hold wr_data at its previous value, and leave last_gnt unchanged.
REQ-018 SHALL keep gnt0 and gnt1 mutually exclusive, and keep we either zero or exactly one bit set.
REQ-019 SHALL produce only one write when both requesters target the same address in the same cycle: the round-robin winner writes and the loser is served in the next cycle.
REQ-020 SHALL sustain one write per cycle while both requesters hold req, alternating 0,1,0,1 and so on.
REQ-021 SHALL decode addresses 3'b000..3'b111 to we bit 0..7 with no out-of-range case.

Reset
REQ-022 SHALL, while reset_n=0, immediately force gnt0=gnt1=0, we=8'h00, wr_data=0 and last_gnt=1, so requester 0 wins the first tie.
REQ-023 SHALL, if reset asserts mid-grant, cancel the pulse at once; the interrupted requester is re-arbitrated normally after release.
REQ-024 SHALL produce no grant on the first rising edge at which reset_n is already 1, provided it was deasserted less than one cycle earlier; arbitration starts on the following edge.

Configuration
REQ-025 SHALL, when macro RF_ARB_FIXED_PRIO_EN is defined, replace REQ-015 with fixed priority: requester 0 always wins a tie, subject to REQ-013, and last_gnt still tracks the winner.
REQ-026 SHALL, when RF_ARB_FIXED_PRIO_EN is undefined, use the round-robin arbitration of REQ-015.

Verification
REQ-027 SHALL verify single request: req0=1, addr0=3'b101, data0=32'hA5A5A5A5 held two cycles -> gnt0=1 and we=8'b0010_0000 with wr_data=32'hA5A5A5A5 in cycle 1 only; no grant in cycle 2.
REQ-028 SHALL verify a tie after reset: req0=req1=1 with addr0=0 and addr1=7, held -> cycle sequence we=01,80,01,80 and gnt alternating 0,1,0,1 (default build).
REQ-029 SHALL verify a same-address tie: addr0=addr1=3 with data 32'h1 and 32'h2 -> we=8'h08 with wr_data=1, then we=8'h08 with wr_data=2, never both in one cycle.
REQ-030 SHALL verify reset mid-grant: drop reset_n during a gnt1 pulse -> all outputs 0 and last_gnt=1 asynchronously; after release with req1 held, gnt1 occurs within 2 cycles.
REQ-031 SHALL verify fixed priority with RF_ARB_FIXED_PRIO_EN defined: req0=req1=1 held -> 0,1,0,1 (REQ-013 forces alternation); req1 held while req0 pulses each cycle it is eligible -> req0 wins every tie.
REQ-032 SHALL verify idle behaviour: no requests for 5 cycles -> we=8'h00, gnt=0, and wr_data and last_gnt stable.
